pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port redirect  input  1  taken branch or jump resolved in EX.
REQ-005 SHALL have port redirect_pc  input  16  next-PC target from branch/jump logic.
REQ-006 SHALL have port stall  input  1  hazard unit holds IF/ID; no new instruction may be delivered.
REQ-007 SHALL have port halt  input  1  HALT decoded in ID.
REQ-008 SHALL have port imem_done  input  1  instruction memory/cache returns data this cycle.
REQ-009 SHALL have port imem_instr  input  16  instruction data, valid with imem_done.
REQ-010 SHALL have port imem_rd  output  1  read request to instruction memory.
REQ-011 SHALL have port imem_addr  output  16  read address, stable while imem_rd high and imem_done low.
REQ-012 SHALL have port pc  output  16  current architectural fetch PC.
REQ-013 SHALL have port if_valid  output  1  one-cycle pulse: if_instr/if_pc_2 valid into IF/ID.
REQ-014 SHALL have port if_instr  output  16  delivered instruction.
REQ-015 SHALL have port if_pc_2  output  16  address of delivered instruction + 2.
REQ-016 SHALL have port flush  output  1  kill younger IF/ID and ID/EX contents.
REQ-017 SHALL have port halted  output  1  fetch stopped by HALT.
REQ-018 SHALL have port err  output  1  one-cycle pulse: misaligned redirect target.

Function
REQ-019 SHALL implement states FETCH, WAIT, DISCARD, HOLD, HALT; one-entry instruction buffer; separate address register for the outstanding access.
REQ-020 FETCH: imem_rd = ~stall & ~redirect, imem_addr = pc; rd & imem_done -> deliver, pc <= pc+2, stay FETCH; rd & ~imem_done -> WAIT, latch address.
REQ-021 WAIT: imem_rd = 1, imem_addr = latched address; done & ~stall -> deliver, pc <= pc+2, FETCH; done & stall -> capture into buffer, pc <= pc+2, HOLD; ~done -> stay.
REQ-022 HOLD: imem_rd = 0; when stall low -> deliver buffered instruction, FETCH.
REQ-023 Deliver SHALL register if_instr, if_pc_2 and pulse if_valid high for exactly the following cycle; if_instr/if_pc_2 hold value otherwise.
REQ-024 redirect SHALL have priority over every other event in every state: flush = redirect (combinational, same cycle); pc <= {redirect_pc[15:1],1'b0}.
REQ-025 redirect in FETCH, HOLD or HALT -> FETCH; buffer dropped, no delivery.
REQ-026 redirect in WAIT with imem_done -> returned data discarded, FETCH; without imem_done -> DISCARD.
REQ-027 DISCARD: imem_rd = 1, imem_addr = latched old address until imem_done; then FETCH with no delivery; further redirect updates pc, stays DISCARD.
REQ-028 err SHALL pulse one cycle after a redirect with redirect_pc[0] = 1.
REQ-029 halt with redirect low: in FETCH -> HALT with no read issued; in WAIT complete and deliver the access first, then HALT; in HOLD deliver then HALT; halt in DISCARD ignored.
REQ-030 HALT: imem_rd = 0, halted = 1, pc frozen; exit only on redirect or rst.
REQ-031 pc+2 SHALL wrap modulo 2^16 (16'hFFFE -> 16'h0000), no flag.
REQ-032 SHALL never have more than one imem access outstanding.

Reset
REQ-033 On rst (asynchronous): state FETCH, pc = RESET_PC, buffer empty, imem_rd, if_valid, flush, halted, err, if_instr, if_pc_2 = 0.
REQ-034 rst mid-access SHALL abandon the outstanding read; any imem_done in first post-reset cycle not preceded by a post-reset imem_rd SHALL be ignored.

Verification
REQ-035 Hit stream: imem_done tied 1, stall 0, RESET_PC 0 -> imem_addr 0,2,4,6 on consecutive cycles; if_valid each cycle, if_pc_2 2,4,6,8.
REQ-036 Miss then stall: done after 3 WAIT cycles with stall high -> HOLD, imem_rd 0, if_valid only after stall drops, pc = addr+2.
REQ-037 Redirect in WAIT: pc 0x0010 outstanding, redirect to 0x0200 -> flush same cycle, DISCARD keeps imem_addr 0x0010 until done, no if_valid, next read 0x0200.
REQ-038 Redirect + halt same cycle, redirect_pc 0x0041 -> halted stays 0, pc 0x0040, err pulse, next fetch 0x0040.
REQ-039 halt in FETCH -> halted 1, imem_rd 0 indefinitely; later redirect 0x0100 -> FETCH, halted 0, read 0x0100.
REQ-040 Wrap: redirect to 0xFFFE, hits -> if_pc_2 0x0000, next imem_addr 0x0000; rst asserted in WAIT -> pc = RESET_PC immediately, no if_valid.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- instruction fetch sequencer for a 16-bit pipeline.
//
// It owns the architectural fetch PC and drives a single-outstanding-access
// instruction memory port. Fetched instructions go to the IF/ID register as a
// one-cycle if_valid pulse. A redirect from EX always wins over every other
// event. A HALT seen in ID stops fetching until the next redirect.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   redirect            taken branch/jump resolved in EX
//   redirect_pc         branch/jump target (bit 0 forced to zero on use)
//   stall               IF/ID held by the hazard unit; nothing may be delivered
//   halt                HALT decoded in ID
//   imem_done           memory returns imem_instr this cycle
//   imem_instr          returned instruction
//   imem_rd, imem_addr  read request and its address
//   pc                  current fetch PC
//   if_valid            one-cycle pulse; if_instr/if_pc_2 are valid
//   if_instr, if_pc_2   delivered instruction and its address + 2
//   flush               kill younger IF/ID and ID/EX contents (same cycle as redirect)
//   halted              fetch is stopped by HALT
//   err                 one-cycle pulse after a redirect to an odd address
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_done,
  input  logic [15:0] imem_instr,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_2,
  output logic        flush,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,  // ready to issue a read at pc
    ST_WAIT    = 3'd1,  // read outstanding, result wanted
    ST_DISCARD = 3'd2,  // read outstanding, result to be thrown away
    ST_HOLD    = 3'd3,  // instruction buffered while IF/ID is stalled
    ST_HALT    = 3'd4   // fetch stopped
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] addr_reg, addr_next;       // address of the outstanding access
  logic [15:0] buf_reg, buf_next;         // one-entry instruction buffer
  logic        halt_pend_reg, halt_pend_next;
  logic        if_valid_reg;
  logic [15:0] if_instr_reg, if_pc_2_reg;
  logic        err_reg;

  logic        deliver;
  logic [15:0] deliver_instr;
  logic [15:0] deliver_pc_2;
  logic        rd_raw;
  logic [15:0] pc_plus2;
  logic [15:0] redirect_target;
  logic        halt_go;

  assign pc_plus2        = pc_reg + 16'd2;   // wraps modulo 2^16
  assign redirect_target = {redirect_pc[15:1], 1'b0};
  // A halt seen while an access was still in flight is remembered, so it
  // takes effect after that access has been delivered even if ID drops it.
  assign halt_go         = halt | halt_pend_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    addr_next      = addr_reg;
    buf_next       = buf_reg;
    halt_pend_next = halt_pend_reg;
    deliver        = 1'b0;
    deliver_instr  = imem_instr;
    deliver_pc_2   = pc_plus2;
    rd_raw         = 1'b0;
    imem_addr      = pc_reg;

    case (state_reg)
      ST_FETCH: begin
        rd_raw         = ~stall & ~redirect & ~halt;
        halt_pend_next = 1'b0;
        if (redirect) begin
          pc_next = redirect_target;
        end else if (halt) begin
          state_next = ST_HALT;
        end else if (rd_raw) begin
          if (imem_done) begin
            deliver = 1'b1;
            pc_next = pc_plus2;
          end else begin
            addr_next  = pc_reg;
            state_next = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        rd_raw    = 1'b1;
        imem_addr = addr_reg;
        if (redirect) begin
          pc_next        = redirect_target;
          halt_pend_next = 1'b0;
          state_next     = imem_done ? ST_FETCH : ST_DISCARD;
        end else if (imem_done) begin
          pc_next = pc_plus2;
          if (!stall) begin
            deliver        = 1'b1;
            halt_pend_next = 1'b0;
            state_next     = halt_go ? ST_HALT : ST_FETCH;
          end else begin
            buf_next       = imem_instr;
            halt_pend_next = halt_go;
            state_next     = ST_HOLD;
          end
        end else begin
          halt_pend_next = halt_go;
        end
      end

      ST_DISCARD: begin
        // The old read must complete before a new one may be issued; its
        // data is dropped. A redirect arriving with the completion has
        // nothing left to wait for.
        rd_raw    = 1'b1;
        imem_addr = addr_reg;
        if (redirect) begin
          pc_next = redirect_target;
        end
        if (imem_done) begin
          state_next = ST_FETCH;
        end
      end

      ST_HOLD: begin
        // pc already points past the buffered instruction.
        deliver_instr = buf_reg;
        deliver_pc_2  = pc_reg;
        if (redirect) begin
          pc_next        = redirect_target;
          halt_pend_next = 1'b0;
          state_next     = ST_FETCH;
        end else if (!stall) begin
          deliver        = 1'b1;
          halt_pend_next = 1'b0;
          state_next     = halt_go ? ST_HALT : ST_FETCH;
        end else begin
          halt_pend_next = halt_go;
        end
      end

      ST_HALT: begin
        halt_pend_next = 1'b0;
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_FETCH;
      pc_reg        <= RESET_PC;
      addr_reg      <= RESET_PC;
      buf_reg       <= 16'h0000;
      halt_pend_reg <= 1'b0;
      if_valid_reg  <= 1'b0;
      if_instr_reg  <= 16'h0000;
      if_pc_2_reg   <= 16'h0000;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      addr_reg      <= addr_next;
      buf_reg       <= buf_next;
      halt_pend_reg <= halt_pend_next;
      if_valid_reg  <= deliver;
      err_reg       <= redirect & redirect_pc[0];
      if (deliver) begin
        if_instr_reg <= deliver_instr;
        if_pc_2_reg  <= deliver_pc_2;
      end
    end
  end

  // While reset is held no request or flush may leave the block.
  assign imem_rd  = rd_raw & ~rst;
  assign flush    = redirect & ~rst;
  assign pc       = pc_reg;
  assign if_valid = if_valid_reg;
  assign if_instr = if_instr_reg;
  assign if_pc_2  = if_pc_2_reg;
  assign halted   = (state_reg == ST_HALT);
  assign err      = err_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed vector table, a reset-during-access
// sequence, then randomized traffic checked against a behavioural model.
module tb_pc_fetch_ctrl;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        halt;
  logic        imem_done;
  logic [15:0] imem_instr;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_2;
  logic        flush;
  logic        halted;
  logic        err;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .halt       (halt),
    .imem_done  (imem_done),
    .imem_instr (imem_instr),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc_2    (if_pc_2),
    .flush      (flush),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        redirect;
    logic [15:0] rpc;
    logic        stall;
    logic        halt;
    logic        done;
    logic [15:0] instr;
    logic        exp_rd;
    logic [15:0] exp_addr;
    logic        exp_flush;
    logic [15:0] exp_pc;
    logic        exp_vld;
    logic [15:0] exp_instr;
    logic [15:0] exp_pc2;
    logic        exp_halted;
    logic        exp_err;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic r, input logic [15:0] rpc, input logic s, input logic h,
    input logic d, input logic [15:0] ins,
    input logic erd, input logic [15:0] eaddr, input logic efl,
    input logic [15:0] epc, input logic evld, input logic [15:0] eins,
    input logic [15:0] epc2, input logic ehl, input logic eerr);
    vec_t v;
    v.redirect = r;   v.rpc = rpc;     v.stall = s;      v.halt = h;
    v.done = d;       v.instr = ins;   v.exp_rd = erd;   v.exp_addr = eaddr;
    v.exp_flush = efl; v.exp_pc = epc; v.exp_vld = evld; v.exp_instr = eins;
    v.exp_pc2 = epc2; v.exp_halted = ehl; v.exp_err = eerr;
    return v;
  endfunction

  // Rows are applied one per cycle right after reset; registered expectations
  // show the effect of the previous rows.
  task automatic fill_vectors();
    // hit stream 0,2,4 then a miss at 6 that completes under stall
    vecs[0]  = mk(0,16'h0000,0,0,1,16'hA000, 1,16'h0000,0, 16'h0000,0,16'h0000,16'h0000,0,0);
    vecs[1]  = mk(0,16'h0000,0,0,1,16'hA002, 1,16'h0002,0, 16'h0002,1,16'hA000,16'h0002,0,0);
    vecs[2]  = mk(0,16'h0000,0,0,1,16'hA004, 1,16'h0004,0, 16'h0004,1,16'hA002,16'h0004,0,0);
    vecs[3]  = mk(0,16'h0000,0,0,0,16'h0000, 1,16'h0006,0, 16'h0006,1,16'hA004,16'h0006,0,0);
    vecs[4]  = mk(0,16'h0000,1,0,0,16'h0000, 1,16'h0006,0, 16'h0006,0,16'h0000,16'h0000,0,0);
    vecs[5]  = mk(0,16'h0000,1,0,0,16'h0000, 1,16'h0006,0, 16'h0006,0,16'h0000,16'h0000,0,0);
    vecs[6]  = mk(0,16'h0000,1,0,1,16'hB006, 1,16'h0006,0, 16'h0006,0,16'h0000,16'h0000,0,0);
    // buffered: no read, stray done ignored, delivery once stall drops
    vecs[7]  = mk(0,16'h0000,1,0,0,16'h0000, 0,16'h0000,0, 16'h0008,0,16'h0000,16'h0000,0,0);
    vecs[8]  = mk(0,16'h0000,1,0,1,16'hFFFF, 0,16'h0000,0, 16'h0008,0,16'h0000,16'h0000,0,0);
    vecs[9]  = mk(0,16'h0000,0,0,0,16'h0000, 0,16'h0000,0, 16'h0008,0,16'h0000,16'h0000,0,0);
    // miss at 8, redirect to 0x0200 while outstanding, old address held
    vecs[10] = mk(0,16'h0000,0,0,0,16'h0000, 1,16'h0008,0, 16'h0008,1,16'hB006,16'h0008,0,0);
    vecs[11] = mk(1,16'h0200,0,0,0,16'h0000, 1,16'h0008,1, 16'h0008,0,16'h0000,16'h0000,0,0);
    vecs[12] = mk(0,16'h0000,0,0,0,16'h0000, 1,16'h0008,0, 16'h0200,0,16'h0000,16'h0000,0,0);
    vecs[13] = mk(0,16'h0000,0,0,1,16'hDEAD, 1,16'h0008,0, 16'h0200,0,16'h0000,16'h0000,0,0);
    vecs[14] = mk(0,16'h0000,0,0,1,16'hC200, 1,16'h0200,0, 16'h0200,0,16'h0000,16'h0000,0,0);
    // redirect + halt together to odd 0x0041
    vecs[15] = mk(1,16'h0041,0,1,1,16'h1111, 0,16'h0000,1, 16'h0202,1,16'hC200,16'h0202,0,0);
    vecs[16] = mk(0,16'h0000,1,0,0,16'h0000, 0,16'h0000,0, 16'h0040,0,16'h0000,16'h0000,0,1);
    vecs[17] = mk(0,16'h0000,0,0,1,16'hC040, 1,16'h0040,0, 16'h0040,0,16'h0000,16'h0000,0,0);
    // halt in FETCH, then redirect to 0x0100 leaves HALT
    vecs[18] = mk(0,16'h0000,0,1,1,16'h2222, 0,16'h0000,0, 16'h0042,1,16'hC040,16'h0042,0,0);
    vecs[19] = mk(0,16'h0000,0,0,1,16'h3333, 0,16'h0000,0, 16'h0042,0,16'h0000,16'h0000,1,0);
    vecs[20] = mk(0,16'h0000,0,0,1,16'h3333, 0,16'h0000,0, 16'h0042,0,16'h0000,16'h0000,1,0);
    vecs[21] = mk(1,16'h0100,0,0,0,16'h0000, 0,16'h0000,1, 16'h0042,0,16'h0000,16'h0000,1,0);
    vecs[22] = mk(0,16'h0000,0,0,1,16'hD100, 1,16'h0100,0, 16'h0100,0,16'h0000,16'h0000,0,0);
    // wrap from 0xFFFE to 0x0000, then a miss left outstanding
    vecs[23] = mk(1,16'hFFFE,0,0,0,16'h0000, 0,16'h0000,1, 16'h0102,1,16'hD100,16'h0102,0,0);
    vecs[24] = mk(0,16'h0000,0,0,1,16'hEFFE, 1,16'hFFFE,0, 16'hFFFE,0,16'h0000,16'h0000,0,0);
    vecs[25] = mk(0,16'h0000,0,0,1,16'hE000, 1,16'h0000,0, 16'h0000,1,16'hEFFE,16'h0000,0,0);
    vecs[26] = mk(0,16'h0000,0,0,0,16'h0000, 1,16'h0002,0, 16'h0002,1,16'hE000,16'h0002,0,0);
    vecs[27] = mk(0,16'h0000,0,0,0,16'h0000, 1,16'h0002,0, 16'h0002,0,16'h0000,16'h0000,0,0);
  endtask

  // ---------------------------------------------------------- reference model
  // Tracks "is an access in flight / will its data be thrown away / is an
  // instruction parked / are we halted" rather than controller states.
  logic [15:0] m_pc, m_addr, m_buf, m_instr, m_pc2;
  logic        m_busy, m_drop, m_buf_full, m_halted, m_halt_pend, m_vld, m_err;

  task automatic model_reset();
    m_pc = RST_PC; m_addr = RST_PC; m_buf = 16'h0; m_instr = 16'h0; m_pc2 = 16'h0;
    m_busy = 0; m_drop = 0; m_buf_full = 0; m_halted = 0; m_halt_pend = 0;
    m_vld = 0; m_err = 0;
  endtask

  function automatic logic model_rd();
    if (rst || m_halted || m_buf_full) return 1'b0;
    if (m_busy) return 1'b1;
    return !stall && !redirect && !halt;
  endfunction

  task automatic model_deliver(input logic [15:0] ins, input logic [15:0] p2);
    m_vld = 1; m_instr = ins; m_pc2 = p2;
  endtask

  // Advance the model across one rising edge using the inputs of the cycle.
  task automatic model_step();
    logic [15:0] tgt;
    tgt   = redirect_pc & 16'hFFFE;
    m_vld = 0;
    m_err = redirect & redirect_pc[0];
    if (redirect) begin
      m_pc = tgt; m_halted = 0; m_buf_full = 0; m_halt_pend = 0;
      if (m_busy) begin
        if (imem_done) begin m_busy = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else if (m_halted) begin
      // frozen
    end else if (m_busy) begin
      if (m_drop) begin
        if (imem_done) begin m_busy = 0; m_drop = 0; end
      end else if (imem_done) begin
        m_busy = 0;
        m_pc   = m_pc + 16'd2;
        if (stall) begin
          m_buf_full = 1; m_buf = imem_instr; m_halt_pend = m_halt_pend | halt;
        end else begin
          model_deliver(imem_instr, m_addr + 16'd2);
          m_halted = halt | m_halt_pend; m_halt_pend = 0;
        end
      end else begin
        m_halt_pend = m_halt_pend | halt;
      end
    end else if (m_buf_full) begin
      if (!stall) begin
        model_deliver(m_buf, m_pc);
        m_buf_full = 0;
        m_halted = halt | m_halt_pend; m_halt_pend = 0;
      end else begin
        m_halt_pend = m_halt_pend | halt;
      end
    end else if (halt) begin
      m_halted = 1;
    end else if (!stall) begin
      if (imem_done) begin
        model_deliver(imem_instr, m_pc + 16'd2);
        m_pc = m_pc + 16'd2;
      end else begin
        m_busy = 1; m_drop = 0; m_addr = m_pc;
      end
    end
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    rst = 1; redirect = 0; redirect_pc = 0; stall = 0; halt = 0;
    imem_done = 0; imem_instr = 0;
    fill_vectors();

    repeat (2) @(negedge clk);
    #1;
    chk("reset pc",       pc,       RST_PC);
    chk("reset imem_rd",  {15'b0, imem_rd},  16'h0);
    chk("reset if_valid", {15'b0, if_valid}, 16'h0);
    chk("reset if_instr", if_instr, 16'h0);
    chk("reset if_pc_2",  if_pc_2,  16'h0);
    chk("reset halted",   {15'b0, halted},   16'h0);
    chk("reset err",      {15'b0, err},      16'h0);
    chk("reset flush",    {15'b0, flush},    16'h0);
    @(negedge clk);
    rst = 0;

    // directed table
    for (int i = 0; i < NV; i++) begin
      redirect = vecs[i].redirect; redirect_pc = vecs[i].rpc;
      stall = vecs[i].stall; halt = vecs[i].halt;
      imem_done = vecs[i].done; imem_instr = vecs[i].instr;
      #1;
      chk($sformatf("v%0d imem_rd", i), {15'b0, imem_rd}, {15'b0, vecs[i].exp_rd});
      if (vecs[i].exp_rd)
        chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d flush", i), {15'b0, flush}, {15'b0, vecs[i].exp_flush});
      chk($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d if_valid", i), {15'b0, if_valid}, {15'b0, vecs[i].exp_vld});
      if (vecs[i].exp_vld) begin
        chk($sformatf("v%0d if_instr", i), if_instr, vecs[i].exp_instr);
        chk($sformatf("v%0d if_pc_2", i), if_pc_2, vecs[i].exp_pc2);
      end
      chk($sformatf("v%0d halted", i), {15'b0, halted}, {15'b0, vecs[i].exp_halted});
      chk($sformatf("v%0d err", i), {15'b0, err}, {15'b0, vecs[i].exp_err});
      $display("vec %0d: rd=%b addr=%h pc=%h vld=%b instr=%h pc2=%h flush=%b halted=%b err=%b",
               i, imem_rd, imem_addr, pc, if_valid, if_instr, if_pc_2, flush, halted, err);
      @(negedge clk);
    end

    // reset while a miss at 0x0002 is outstanding: takes effect immediately
    redirect = 0; stall = 0; halt = 0; imem_done = 0;
    #2 rst = 1;
    #1;
    chk("rst-in-wait pc",       pc, RST_PC);
    chk("rst-in-wait imem_rd",  {15'b0, imem_rd},  16'h0);
    chk("rst-in-wait if_valid", {15'b0, if_valid}, 16'h0);
    $display("seq rst-in-wait: pc=%h rd=%b vld=%b", pc, imem_rd, if_valid);
    @(negedge clk);
    rst = 0;
    // stray completion in the first cycle after reset, no request issued
    stall = 1; imem_done = 1; imem_instr = 16'hBAD0;
    #1;
    chk("post-rst imem_rd", {15'b0, imem_rd}, 16'h0);
    @(negedge clk);
    #1;
    chk("post-rst if_valid", {15'b0, if_valid}, 16'h0);
    chk("post-rst pc", pc, RST_PC);
    stall = 0; imem_instr = 16'h1234;
    #1;
    chk("post-rst rd",   {15'b0, imem_rd}, 16'h1);
    chk("post-rst addr", imem_addr, RST_PC);
    @(negedge clk);
    #1;
    chk("post-rst deliver vld",   {15'b0, if_valid}, 16'h1);
    chk("post-rst deliver instr", if_instr, 16'h1234);
    chk("post-rst deliver pc2",   if_pc_2, RST_PC + 16'd2);
    $display("seq post-rst: vld=%b instr=%h pc2=%h", if_valid, if_instr, if_pc_2);

    // randomized traffic against the model
    @(negedge clk);
    rst = 1; model_reset();
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 4000; c++) begin
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = 16'($urandom);
      stall       = ($urandom_range(0, 99) < 30);
      halt        = ($urandom_range(0, 99) < 6);
      imem_done   = ($urandom_range(0, 99) < 45);
      imem_instr  = 16'($urandom);
      rst         = ($urandom_range(0, 299) == 0);
      if (rst) model_reset();
      #1;
      chk("rnd imem_rd", {15'b0, imem_rd}, {15'b0, model_rd()});
      if (model_rd())
        chk("rnd imem_addr", imem_addr, m_busy ? m_addr : m_pc);
      chk("rnd flush",    {15'b0, flush},    {15'b0, redirect & ~rst});
      chk("rnd pc",       pc,                m_pc);
      chk("rnd if_valid", {15'b0, if_valid}, {15'b0, m_vld});
      chk("rnd if_instr", if_instr,          m_instr);
      chk("rnd if_pc_2",  if_pc_2,           m_pc2);
      chk("rnd halted",   {15'b0, halted},   {15'b0, m_halted});
      chk("rnd err",      {15'b0, err},      {15'b0, m_err});
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
